// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port, byte-serial memory controller shared by the load/store
// buffer (LSB) and instruction fetch (IF).
//
// Requests are arbitrated in IDLE (store > load > fetch). Multi-byte accesses
// are split into byte transfers on one 8-bit RAM/IO bus, little-endian.
// Each requester gets a one-cycle done pulse when its access completes.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-low reset
//   rdy_in                global ready; low freezes the block (mem_wr forced 0)
//   clear                 flush: aborts reads and blocks acceptance in IDLE
//   data_r_en/data_w_en   LSB load/store request levels
//   data_addr/val/len     LSB address, store data, length (1, 2, 4; other -> 4)
//   LSB_en_o/LSB_data_o   LSB done pulse and zero-extended load result
//   if_en/if_addr         fetch request level and address (always 4 bytes)
//   if_en_o/if_data_o     fetch done pulse and instruction word
//   mem_din               read byte for the address driven last cycle
//   mem_dout/mem_a/mem_wr write byte, byte address, write strobe
//   io_buffer_full        stalls stores to IO space (addr[17:16] == IO_SEL)
//   dbg_state_o           current FSM state, for observation only
//
// Handshake: a request is a level held by the requester until its done pulse;
// the pulse is high for exactly one cycle (DONE) and the requester drops the
// request on the edge that ends DONE, so DONE never accepts.
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              data_r_en,
    input  logic              data_w_en,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_val,
    input  logic [31:0]       data_len,
    output logic              LSB_en_o,
    output logic [31:0]       LSB_data_o,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_en_o,
    output logic [31:0]       if_data_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        len_q, len_d;
    logic [31:0]       val_q, val_d;
    logic              own_if_q, own_if_d;
    logic [2:0]        k_q, k_d;        // next byte to issue
    logic [2:0]        c_q, c_d;        // next byte to capture
    logic [31:0]       res_q, res_d;
    logic              iss_q, iss_d;    // mem_a holds a fresh read issue this cycle
    logic              rvld_q, rvld_d;  // mem_din holds a requested byte this cycle
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              lsb_en_q, lsb_en_d;
    logic              if_en_q, if_en_d;
    logic [31:0]       lsb_data_q, lsb_data_d;
    logic [31:0]       if_data_q, if_data_d;

    logic [ADDR_W-1:0] acc_addr;
    logic              acc_stall;
    logic              unused_len_hi;

    assign unused_len_hi = ^data_len[31:3];

    function automatic logic [2:0] decode_len(input logic [2:0] l);
        case (l)
            3'd1, 3'd2, 3'd4: return l;
            default:          return 3'd4;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        val_d      = val_q;
        own_if_d   = own_if_q;
        k_d        = k_q;
        c_d        = c_q;
        res_d      = res_q;
        iss_d      = 1'b0;
        rvld_d     = 1'b0;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        lsb_en_d   = 1'b0;
        if_en_d    = 1'b0;
        lsb_data_d = lsb_data_q;
        if_data_d  = if_data_q;
        acc_addr   = '0;
        acc_stall  = 1'b0;

        if (!rdy_in) begin
            // Frozen. A read rewinds its issue index so the byte lost while
            // frozen is requested again once ready returns.
            lsb_en_d = lsb_en_q;
            if_en_d  = if_en_q;
            if (state_q == READ) k_d = c_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!clear && (data_w_en || data_r_en || if_en)) begin
                        acc_addr   = (data_w_en || data_r_en) ? data_addr : if_addr;
                        own_if_d   = !(data_w_en || data_r_en);
                        addr_d     = acc_addr;
                        val_d      = data_val;
                        len_d      = own_if_d ? 3'd4 : decode_len(data_len[2:0]);
                        c_d        = 3'd0;
                        res_d      = '0;
                        // The first byte goes out on the accepting edge.
                        mem_a_d    = acc_addr;
                        mem_dout_d = data_val[7:0];
                        if (data_w_en) begin
                            acc_stall = (acc_addr[17:16] == IO_SEL) && io_buffer_full;
                            mem_wr_d  = !acc_stall;
                            k_d       = acc_stall ? 3'd0 : 3'd1;
                            state_d   = WRITE;
                        end else begin
                            k_d     = 3'd1;
                            iss_d   = 1'b1;
                            state_d = READ;
                        end
                    end
                end
                READ: begin
                    if (clear) begin
                        state_d = IDLE;
                    end else begin
                        rvld_d = iss_q;
                        if (k_q < len_q) begin
                            mem_a_d = addr_q + ADDR_W'(k_q);
                            k_d     = k_q + 3'd1;
                            iss_d   = 1'b1;
                        end
                        if (rvld_q) begin
                            res_d[{c_q[1:0], 3'b000} +: 8] = mem_din;
                            c_d = c_q + 3'd1;
                            if (c_d == len_q) begin
                                state_d = DONE;
                                if (own_if_q) begin
                                    if_en_d   = 1'b1;
                                    if_data_d = res_d;
                                end else begin
                                    lsb_en_d   = 1'b1;
                                    lsb_data_d = res_d;
                                end
                            end
                        end
                    end
                end
                WRITE: begin
                    // Stores ignore clear: they are already committed.
                    if (k_q == len_q) begin
                        state_d  = DONE;
                        lsb_en_d = 1'b1;
                    end else begin
                        mem_a_d    = addr_q + ADDR_W'(k_q);
                        mem_dout_d = val_q[{k_q[1:0], 3'b000} +: 8];
                        if (!((addr_q[17:16] == IO_SEL) && io_buffer_full)) begin
                            mem_wr_d = 1'b1;
                            k_d      = k_q + 3'd1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            val_q      <= '0;
            own_if_q   <= 1'b0;
            k_q        <= '0;
            c_q        <= '0;
            res_q      <= '0;
            iss_q      <= 1'b0;
            rvld_q     <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            lsb_en_q   <= 1'b0;
            if_en_q    <= 1'b0;
            lsb_data_q <= '0;
            if_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            val_q      <= val_d;
            own_if_q   <= own_if_d;
            k_q        <= k_d;
            c_q        <= c_d;
            res_q      <= res_d;
            iss_q      <= iss_d;
            rvld_q     <= rvld_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            lsb_en_q   <= lsb_en_d;
            if_en_q    <= if_en_d;
            lsb_data_q <= lsb_data_d;
            if_data_q  <= if_data_d;
        end
    end

    assign LSB_en_o    = lsb_en_q;
    assign LSB_data_o  = lsb_data_q;
    assign if_en_o     = if_en_q;
    assign if_data_o   = if_data_q;
    assign mem_a       = mem_a_q;
    assign mem_dout    = mem_dout_q;
    assign mem_wr      = mem_wr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte RAM model with one-cycle read latency, scenario
// tasks with inline checks, expected results queued when stimulus is driven.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic        data_r_en, data_w_en;
    logic [31:0] data_addr, data_val, data_len;
    logic        LSB_en_o;
    logic [31:0] LSB_data_o;
    logic        if_en;
    logic [31:0] if_addr;
    logic        if_en_o;
    logic [31:0] if_data_o;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic [1:0]  dbg_state_o;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .data_r_en(data_r_en), .data_w_en(data_w_en), .data_addr(data_addr),
        .data_val(data_val), .data_len(data_len), .LSB_en_o(LSB_en_o),
        .LSB_data_o(LSB_data_o), .if_en(if_en), .if_addr(if_addr),
        .if_en_o(if_en_o), .if_data_o(if_data_o), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .dbg_state_o(dbg_state_o)
    );

    logic [7:0] ram [0:1023];
    always @(posedge clk) mem_din <= ram[mem_a[9:0]];

    logic [31:0] exp_q[$];
    logic [31:0] a_log[$];
    logic [31:0] wr_a[$];
    logic [7:0]  wr_d[$];
    int          wr_c[$];
    int          lsb_pulses, if_pulses;
    int          n_checks = 0;
    int          n_pass = 0;

    // Observe bus and pulses each cycle until the wanted pulse or the budget
    // runs out (at = -1). Drops the owner's request like a real requester.
    task automatic wait_pulse(input bit want_if, input int budget,
                              output int at, output logic [31:0] d);
        at = -1; d = '0;
        a_log.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
        lsb_pulses = 0; if_pulses = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            a_log.push_back(mem_a);
            if (mem_wr) begin
                wr_a.push_back(mem_a); wr_d.push_back(mem_dout); wr_c.push_back(cyc);
            end
            if (LSB_en_o) lsb_pulses++;
            if (if_en_o) if_pulses++;
            if (want_if ? if_en_o : LSB_en_o) begin
                at = cyc;
                d  = want_if ? if_data_o : LSB_data_o;
                if (want_if) if_en = 1'b0;
                else begin data_r_en = 1'b0; data_w_en = 1'b0; end
                break;
            end
        end
    endtask

    task automatic start_lsb(input bit wr, input logic [31:0] a, input logic [31:0] v,
                             input logic [31:0] l);
        @(posedge clk); #1;
        data_addr = a; data_val = v; data_len = l;
        data_w_en = wr; data_r_en = !wr;
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w[i*8 +: 8] = ram[(a + i) & 32'h3FF];
        return w;
    endfunction

    task automatic test_reset();
        #2;
        n_checks++; if (mem_a !== 32'h0 || mem_dout !== 8'h0)
            $display("FAIL reset_bus: mem_a=%h mem_dout=%h want 0", mem_a, mem_dout); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0 || LSB_en_o !== 1'b0 || if_en_o !== 1'b0)
            $display("FAIL reset_strobes: wr=%b lsb=%b if=%b want 0", mem_wr, LSB_en_o, if_en_o); else n_pass++;
        n_checks++; if (LSB_data_o !== 32'h0 || if_data_o !== 32'h0)
            $display("FAIL reset_data: lsb=%h if=%h want 0", LSB_data_o, if_data_o); else n_pass++;
        n_checks++; if (dbg_state_o !== 2'd0)
            $display("FAIL reset_state: got %0d want 0", dbg_state_o); else n_pass++;
        @(negedge clk); rst_in = 1'b1;
    endtask

    task automatic test_lw();
        int at, bad; logic [31:0] d, e;
        start_lsb(1'b0, 32'h100, 32'h0, 32'd4);
        exp_q.push_back(32'h44332211);
        wait_pulse(1'b0, 40, at, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
        n_checks++; if (d !== e) $display("FAIL lw_data: got %h want %h", d, e); else n_pass++;
        n_checks++; if (at !== 6) $display("FAIL lw_latency: got %0d want 6", at); else n_pass++;
        bad = 0;
        for (int i = 1; i <= 4; i++)
            if (a_log.size() <= i || a_log[i] !== 32'h100 + i - 1) bad++;
        n_checks++; if (bad !== 0) $display("FAIL lw_addr_seq: %0d wrong addresses want 0", bad); else n_pass++;
        n_checks++; if (wr_a.size() !== 0) $display("FAIL lw_no_write: %0d writes want 0", wr_a.size()); else n_pass++;
        @(negedge clk);
        n_checks++; if (LSB_en_o !== 1'b0) $display("FAIL lw_pulse_width: got %b want 0", LSB_en_o); else n_pass++;
        n_checks++; if (LSB_data_o !== 32'h44332211) $display("FAIL lw_data_hold: got %h want 44332211", LSB_data_o); else n_pass++;
    endtask

    task automatic test_lbu();
        int at; logic [31:0] d, e;
        start_lsb(1'b0, 32'h105, 32'h0, 32'd1);
        exp_q.push_back(32'h0000009A);
        wait_pulse(1'b0, 40, at, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
        n_checks++; if (d !== e) $display("FAIL lbu_data: got %h want %h", d, e); else n_pass++;
        n_checks++; if (at !== 3) $display("FAIL lbu_latency: got %0d want 3", at); else n_pass++;
    endtask

    task automatic test_sw();
        int at, bad; logic [31:0] d, e;
        start_lsb(1'b1, 32'h200, 32'hDEADBEEF, 32'd4);
        exp_q.push_back(32'hEF); exp_q.push_back(32'hBE);
        exp_q.push_back(32'hAD); exp_q.push_back(32'hDE);
        wait_pulse(1'b0, 40, at, d);
        n_checks++; if (wr_a.size() !== 4) $display("FAIL sw_write_count: got %0d want 4", wr_a.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < wr_a.size() && i < 4; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
            if (wr_a[i] !== 32'h200 + i || {24'h0, wr_d[i]} !== e || wr_c[i] !== i + 1) bad++;
        end
        exp_q.delete();
        n_checks++; if (bad !== 0) $display("FAIL sw_bytes: %0d wrong writes want 0", bad); else n_pass++;
        n_checks++; if (at !== 5) $display("FAIL sw_latency: got %0d want 5", at); else n_pass++;
    endtask

    task automatic test_io_stall();
        int at; logic [31:0] d, e;
        io_buffer_full = 1'b1;
        start_lsb(1'b1, 32'h30000, 32'h0000005A, 32'd1);
        exp_q.push_back(32'h5A);
        fork begin repeat (3) @(posedge clk); #1 io_buffer_full = 1'b0; end join_none
        wait_pulse(1'b0, 40, at, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
        n_checks++; if (wr_a.size() !== 1) $display("FAIL io_write_count: got %0d want 1", wr_a.size()); else n_pass++;
        n_checks++; if (wr_a.size() > 0 && (wr_c[0] !== 4 || wr_a[0] !== 32'h30000 || {24'h0, wr_d[0]} !== e))
            $display("FAIL io_write: cyc=%0d addr=%h data=%h want cyc 4 addr 30000 data %h",
                     wr_c[0], wr_a[0], wr_d[0], e); else n_pass++;
        n_checks++; if (at !== 5) $display("FAIL io_latency: got %0d want 5", at); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int at; logic [31:0] d, e;
        @(posedge clk); #1;
        data_addr = 32'h100; data_len = 32'd4; data_r_en = 1'b1;
        if_addr = 32'h0; if_en = 1'b1;
        exp_q.push_back(32'h44332211); exp_q.push_back(32'h00500093);
        wait_pulse(1'b0, 40, at, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
        n_checks++; if (d !== e || at !== 6) $display("FAIL arb_lsb_first: data=%h at=%0d want %h at 6", d, at, e); else n_pass++;
        n_checks++; if (if_pulses !== 0) $display("FAIL arb_if_early: %0d pulses want 0", if_pulses); else n_pass++;
        wait_pulse(1'b1, 40, at, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
        n_checks++; if (d !== e) $display("FAIL arb_if_data: got %h want %h", d, e); else n_pass++;
        n_checks++; if (at !== 6) $display("FAIL arb_if_latency: got %0d want 6", at); else n_pass++;
    endtask

    task automatic test_if_clear();
        int at; logic [31:0] d, e;
        @(posedge clk); #1;
        if_addr = 32'h0; if_en = 1'b1;
        exp_q.push_back(32'h00500093);
        fork begin repeat (2) @(posedge clk); #1 clear = 1'b1; @(posedge clk); #1 clear = 1'b0; end join_none
        wait_pulse(1'b1, 40, at, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
        n_checks++; if (at !== 9) $display("FAIL clear_abort: first if pulse at %0d want 9", at); else n_pass++;
        n_checks++; if (d !== e) $display("FAIL clear_refetch_data: got %h want %h", d, e); else n_pass++;
    endtask

    task automatic test_rdy_stall();
        int at; logic [31:0] d, e;
        start_lsb(1'b0, 32'h100, 32'h0, 32'd4);
        exp_q.push_back(32'h44332211);
        fork begin repeat (2) @(posedge clk); #1 rdy_in = 1'b0; repeat (2) @(posedge clk); #1 rdy_in = 1'b1; end join_none
        wait_pulse(1'b0, 40, at, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
        n_checks++; if (d !== e || at < 0) $display("FAIL rdy_data: got %h at %0d want %h", d, at, e); else n_pass++;
        n_checks++; if (wr_a.size() !== 0) $display("FAIL rdy_no_write: %0d writes want 0", wr_a.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        int at; logic [31:0] d, e;
        start_lsb(1'b0, 32'hFFFF_FFFE, 32'h0, 32'd4);
        exp_q.push_back(ram_word(32'hFFFF_FFFE, 4));
        wait_pulse(1'b0, 40, at, d);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
        n_checks++; if (d !== e) $display("FAIL wrap_data: got %h want %h", d, e); else n_pass++;
        n_checks++; if (a_log.size() < 5 || a_log[2] !== 32'hFFFF_FFFF || a_log[3] !== 32'h0)
            $display("FAIL wrap_addr: addresses do not wrap to 0 after FFFFFFFF"); else n_pass++;
    endtask

    task automatic test_random_loads();
        int at, dl; logic [31:0] a, l, d, e;
        for (int n = 0; n < 8; n++) begin
            a = 32'h300 + $urandom_range(0, 200);
            case ($urandom_range(0, 3))
                0: l = 32'd1;
                1: l = 32'd2;
                2: l = 32'd4;
                default: l = 32'd3;
            endcase
            dl = (l == 32'd3) ? 4 : int'(l);
            start_lsb(1'b0, a, 32'h0, l);
            exp_q.push_back(ram_word(a, dl));
            wait_pulse(1'b0, 40, at, d);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
            n_checks++; if (d !== e) $display("FAIL rand_data: addr %h len %0d got %h want %h", a, l, d, e); else n_pass++;
            n_checks++; if (at !== dl + 2) $display("FAIL rand_latency: len %0d got %0d want %0d", l, at, dl + 2); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[0] = 8'h93; ram[1] = 8'h00; ram[2] = 8'h50; ram[3] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h105] = 8'h9A;
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
        data_r_en = 1'b0; data_w_en = 1'b0; data_addr = '0; data_val = '0; data_len = '0;
        if_en = 1'b0; if_addr = '0; io_buffer_full = 1'b0;
        test_reset();
        test_lw();
        test_lbu();
        test_sw();
        test_io_stall();
        test_back_to_back();
        test_if_clear();
        test_rdy_stall();
        test_wrap();
        test_random_loads();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port, byte-serial memory controller directly downstream of the load/store buffer.
- Also serves instruction fetch.
- Arbitrates LSB load/store and IF 4-byte fetch requests onto one 8-bit RAM/IO bus (mem_a/mem_din/mem_dout/mem_wr).
- Assembles or splits multi-byte words and returns one-cycle done pulses (LSB_en_o, if_en_o) to the requesters.
- Stalls IO-space stores while io_buffer_full is high.

Parameters:
- ADDR_W, 32, address width of mem_a and all request addresses.
- IO_SEL, 2'b11, value of addr[17:16] that marks IO space.

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low freezes the block.
- clear  input  1  pipeline flush from ROB.
- data_r_en  input  1  LSB load request, level, held until LSB_en_o.
- data_w_en  input  1  LSB store request, level, held until LSB_en_o.
- data_addr  input  32  LSB byte address.
- data_val  input  32  LSB store data, little-endian, low data_len bytes used.
- data_len  input  32  LSB access length in bytes (1, 2, 4).
- LSB_en_o  output  1  LSB done pulse, one cycle.
- LSB_data_o  output  32  load result, zero-extended, valid with LSB_en_o.
- if_en  input  1  fetch request, level.
- if_addr  input  32  fetch address.
- if_en_o  output  1  fetch done pulse, one cycle.
- if_data_o  output  32  fetched instruction, valid with if_en_o.
- mem_din  input  8  RAM/IO read byte; corresponds to mem_a of the previous cycle.
- mem_dout  output  8  write byte.
- mem_a  output  32  byte address.
- mem_wr  output  1  1 = write, 0 = read.
- io_buffer_full  input  1  IO output buffer full.

Behaviour:
- Reset (rst_in=0, async): state IDLE; mem_a, mem_dout, LSB_data_o and if_data_o = 0; mem_wr, LSB_en_o and if_en_o = 0; counters 0.
- States: IDLE, READ, WRITE, DONE.
- Length decode: len = data_len[2:0]; values 1, 2 and 4 are used as-is; any other value is treated as 4. IF is always len 4.
- Arbitration in IDLE, evaluated each cycle:
  - data_w_en wins over data_r_en, which wins over if_en.
  - On accept, latch addr, len, val and owner (LSB/IF).
  - Set issue index k=0 and capture index c=0.
- READ:
  - Each cycle with k<len: mem_a <= base+k, mem_wr <= 0, k++.
  - Each cycle: byte c of the result <= mem_din from the address issued last cycle, c++.
  - When c==len → DONE.
  - Latency: request high in cycle 0 → mem_a=base in cycle 1 → done pulse in cycle len+2.
- WRITE: per cycle drive mem_a=base+k, mem_dout=val byte k, mem_wr=1, k++. After len bytes → DONE; done pulse in cycle len+1.
- IO stall: if addr[17:16]==IO_SEL and io_buffer_full=1 in a WRITE cycle, then mem_wr=0 and k is held. RAM-space stores ignore io_buffer_full.
- DONE, one cycle:
  - The owner's done pulse is high and its data output is valid.
  - Unused upper result bytes are 0 (sign extension is done in the LSB).
  - Next state is IDLE. No accept occurs in DONE, because requesters drop their enable on the edge ending DONE.
- mem_wr returns to 0 in any non-write cycle. Data outputs hold their last value between pulses.
- clear=1:
  - An in-progress READ (LSB or IF) aborts: no done pulse; the next state is IDLE.
  - An in-progress WRITE always completes (stores are committed).
  - clear in IDLE blocks acceptance that cycle.
- rdy_in=0:
  - State, counters and outputs are frozen, except mem_wr, which is forced to 0.
  - For READ, k is rewound to c, so the first byte re-issued after resume is recaptured one cycle later.
- Wrap: base+k wraps modulo 2^ADDR_W.
- Reset mid-transfer: immediate return to IDLE; no pulse.

Test Plan:
- LSB lw addr=0x100 with RAM bytes 11,22,33,44: mem_a = 0x100..0x103 in cycles 1-4; LSB_en_o high in cycle 6 with LSB_data_o=0x44332211.
- LSB lbu addr=0x105 with byte 0x9A: LSB_data_o=0x0000009A; done in cycle 3.
- sw data_val=0xDEADBEEF addr=0x200: mem_wr=1 for 4 cycles with bytes EF,BE,AD,DE at 0x200-0x203; LSB_en_o in cycle 5.
- sb to 0x30000 with io_buffer_full high for 3 cycles: mem_wr stays 0 for those 3 cycles, then one write of the byte; done one cycle later.
- if_en and data_r_en asserted together: the LSB load completes first, then the IF fetch starts in the IDLE cycle that follows.
- IF fetch at 0x0 with clear pulsed in cycle 2: no if_en_o pulse; the next if_en is accepted in the following IDLE cycle.
- rdy_in low for 2 cycles mid-lw: the result is still 0x44332211 and mem_wr stays 0 throughout.
